// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels and the shared ALU port
// of alu_arbiter.
//   req0/req1 : valid/ready request channel carrying a 3-bit opcode and
//               two WIDTH-bit operands
//   rsp0/rsp1 : valid/ready response channel returning result, zero, err
//   alu_*     : operands and one-hot select to the combinational ALU,
//               with its result and zero flag coming back
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;
  logic             rsp1_err;

  logic [WIDTH-1:0] alu_operand_a;
  logic [WIDTH-1:0] alu_operand_b;
  logic             alu_sel_add;
  logic             alu_sel_sub;
  logic             alu_sel_and;
  logic             alu_sel_or;
  logic             alu_sel_slt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero_flag;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_operand_a, alu_operand_b,
    output alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt,
    input  alu_result, alu_zero_flag
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_operand_a, alu_operand_b,
    input  alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt,
    output alu_result, alu_zero_flag
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin arbitration. One transaction is in flight at a time:
// IDLE (arbitrate + latch) -> EXEC (drive ALU, capture) -> RESP (hold until
// the owner accepts).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_arbiter_if.slave, request/response channels and ALU port
//   busy : high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             owner;
  logic             ptr;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             err_p1;
  logic             grant0, grant1;
  logic             rsp_hs;
  logic [4:0]       sel;

  // One-hot select {slt, or, and, sub, add}; illegal opcodes select nothing.
  function automatic logic [4:0] op_decode(input logic [2:0] op);
    case (op)
      3'd0:    op_decode = 5'b00001;
      3'd1:    op_decode = 5'b00010;
      3'd2:    op_decode = 5'b00100;
      3'd3:    op_decode = 5'b01000;
      3'd4:    op_decode = 5'b10000;
      default: op_decode = 5'b00000;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= 3'd4);
  endfunction

  // On a tie the pointer picks the winner; a lone valid always wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
    grant1 = bus.req1_valid & (~bus.req0_valid |  ptr);
    rsp_hs = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.req0_ready    = 1'b0;
    bus.req1_ready    = 1'b0;
    bus.alu_operand_a = '0;
    bus.alu_operand_b = '0;
    sel               = 5'b00000;
    case (state)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        bus.req0_ready = grant0 & ~rst;
        bus.req1_ready = grant1 & ~rst;
        if (grant0 | grant1) state_nxt = EXEC;
      end
      EXEC: begin
        bus.alu_operand_a = a_p0;
        bus.alu_operand_b = b_p0;
        sel               = op_decode(op_p0);
        state_nxt         = RESP;
      end
      RESP: begin
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.alu_sel_add = sel[0];
    bus.alu_sel_sub = sel[1];
    bus.alu_sel_and = sel[2];
    bus.alu_sel_or  = sel[3];
    bus.alu_sel_slt = sel[4];
    busy            = (state != IDLE);
    bus.rsp0_valid  = (state == RESP) & ~owner;
    bus.rsp1_valid  = (state == RESP) &  owner;
    bus.rsp0_result = bus.rsp0_valid ? result_p1 : '0;
    bus.rsp0_zero   = bus.rsp0_valid & zero_p1;
    bus.rsp0_err    = bus.rsp0_valid & err_p1;
    bus.rsp1_result = bus.rsp1_valid ? result_p1 : '0;
    bus.rsp1_zero   = bus.rsp1_valid & zero_p1;
    bus.rsp1_err    = bus.rsp1_valid & err_p1;
  end

  // Stage p0: request latched at the IDLE handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 1'b0;
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
    end else if (state == IDLE && (grant0 | grant1)) begin
      owner <= grant1;
      op_p0 <= grant1 ? bus.req1_op : bus.req0_op;
      a_p0  <= grant1 ? bus.req1_a  : bus.req0_a;
      b_p0  <= grant1 ? bus.req1_b  : bus.req0_b;
    end
  end

  // Stage p1: ALU result captured at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else if (state == EXEC) begin
      if (op_legal(op_p0)) begin
        result_p1 <= bus.alu_result;
        zero_p1   <= bus.alu_zero_flag;
        err_p1    <= 1'b0;
      end else begin
        result_p1 <= '0;
        zero_p1   <= 1'b1;
        err_p1    <= 1'b1;
      end
    end
  end

  // The pointer hands the next tie to whoever was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (rsp_hs) ptr <= ~owner;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  logic [4:0] sels;
  assign sels = {bus.alu_sel_slt, bus.alu_sel_or, bus.alu_sel_and,
                 bus.alu_sel_sub, bus.alu_sel_add};

  // Reference ALU driven by the select lines.
  always_comb begin
    bus.alu_result = '0;
    if (bus.alu_sel_add) bus.alu_result = bus.alu_operand_a + bus.alu_operand_b;
    if (bus.alu_sel_sub) bus.alu_result = bus.alu_operand_a - bus.alu_operand_b;
    if (bus.alu_sel_and) bus.alu_result = bus.alu_operand_a & bus.alu_operand_b;
    if (bus.alu_sel_or)  bus.alu_result = bus.alu_operand_a | bus.alu_operand_b;
    if (bus.alu_sel_slt)
      bus.alu_result = {{(WIDTH-1){1'b0}},
                        ($signed(bus.alu_operand_a) < $signed(bus.alu_operand_b))};
    bus.alu_zero_flag = (bus.alu_result == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic             owner;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  bit   exec_pend = 0;

  function automatic logic [4:0] exp_sel(input logic [2:0] op);
    case (op)
      3'd0: exp_sel = 5'b00001;
      3'd1: exp_sel = 5'b00010;
      3'd2: exp_sel = 5'b00100;
      3'd3: exp_sel = 5'b01000;
      3'd4: exp_sel = 5'b10000;
      default: exp_sel = 5'b00000;
    endcase
  endfunction

  function automatic txn_t make_txn(input logic n, input logic [2:0] op,
                                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    txn_t t;
    t.owner = n; t.op = op; t.a = a; t.b = b; t.err = 1'b0;
    case (op)
      3'd0: t.res = a + b;
      3'd1: t.res = a - b;
      3'd2: t.res = a & b;
      3'd3: t.res = a | b;
      3'd4: t.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin t.res = '0; t.err = 1'b1; end
    endcase
    t.zero = (t.res == '0);
    return t;
  endfunction

  // Monitor: scoreboard push on request handshakes, pop on response
  // handshakes, and per-cycle checks of the ALU port and idle responses.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exec_pend = 0;
    end else begin
      if (exec_pend) begin
        chk("exec_sel", {59'd0, sels}, {59'd0, exp_sel(cur.op)});
        chk("exec_opnd", {bus.alu_operand_a, bus.alu_operand_b}, {cur.a, cur.b});
        exec_pend = 0;
      end else begin
        chk("idle_sel", {59'd0, sels}, 64'd0);
        chk("idle_opnd", {bus.alu_operand_a, bus.alu_operand_b}, 64'd0);
      end
      chk("both_ready", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
      if (bus.req0_valid && bus.req0_ready) begin
        cur = make_txn(1'b0, bus.req0_op, bus.req0_a, bus.req0_b);
        sb.push_back(cur);
        exec_pend = 1;
      end else if (bus.req1_valid && bus.req1_ready) begin
        cur = make_txn(1'b1, bus.req1_op, bus.req1_a, bus.req1_b);
        sb.push_back(cur);
        exec_pend = 1;
      end
      if (!bus.rsp0_valid)
        chk("rsp0_quiet", {bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err}, 64'd0);
      if (!bus.rsp1_valid)
        chk("rsp1_quiet", {bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err}, 64'd0);
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          txn_t t;
          t = sb.pop_front();
          if (bus.rsp0_valid) begin
            chk("rsp_owner", 64'd0, {63'd0, t.owner});
            chk("rsp0_data", {bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err},
                {t.res, t.zero, t.err});
          end else begin
            chk("rsp_owner", 64'd1, {63'd0, t.owner});
            chk("rsp1_data", {bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err},
                {t.res, t.zero, t.err});
          end
        end
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic drain(input int n);
    bit seen = 0;
    @(posedge clk); #1;
    if (n == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (n == 0 ? bus.rsp0_valid : bus.rsp1_valid) seen = 1;
    end
    chk("drain_seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic serve(input int n, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit got = 0;
    @(posedge clk); #1;
    set_req(n, 1'b1, op, a, b);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (n == 0 ? bus.req0_ready : bus.req1_ready) got = 1;
    end
    chk("serve_grant", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    set_req(n, 1'b0, 3'd0, '0, '0);
    drain(n);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    chk("rst_rspv", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
    chk("rst_sel", {59'd0, sels}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;

    // Single ADD with explicit cycle timing
    set_req(0, 1'b1, 3'd0, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    chk("add_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    chk("add_exec_sel", {59'd0, sels}, 64'd1);
    chk("add_exec_opnd", {bus.alu_operand_a, bus.alu_operand_b}, {32'd5, 32'd7});
    chk("add_exec_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("add_rsp", {bus.rsp0_valid, bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err},
        {1'b1, 32'd12, 1'b0, 1'b0});
    drain(0);

    // Contention after reset: 0 first, then 1 wins the next tie
    pulse_reset();
    set_req(0, 1'b1, 3'd1, 32'd9, 32'd9);
    set_req(1, 1'b1, 3'd1, 32'd9, 32'd9);
    @(negedge clk);
    chk("tie1_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    chk("tie1_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    drain(0);
    set_req(0, 1'b1, 3'd0, 32'd4, 32'd4);
    @(negedge clk);
    chk("tie2_rdy1", {63'd0, bus.req1_ready}, 64'd1);
    chk("tie2_rdy0", {63'd0, bus.req0_ready}, 64'd0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'd0, '0, '0);
    drain(1);
    @(negedge clk);
    chk("tie3_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    drain(0);

    // Backpressure on requester 1 while requester 0 waits
    @(posedge clk); #1;
    set_req(1, 1'b1, 3'd3, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    chk("bp_rdy1", {63'd0, bus.req1_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'd0, '0, '0);
    set_req(0, 1'b1, 3'd0, 32'd1, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.rsp1_valid, bus.rsp1_result, busy, bus.req0_ready, bus.req1_ready},
          {1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0});
    end
    drain(1);
    @(negedge clk);
    chk("bp_next_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    drain(0);

    // Illegal opcode
    @(posedge clk); #1;
    set_req(1, 1'b1, 3'd6, 32'd3, 32'd4);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    chk("ill_exec_sel", {58'd0, busy, sels}, {58'd0, 1'b1, 5'd0});
    drain(1);

    // Every legal opcode, including SLT on signed operands
    for (int op = 0; op < 5; op++) begin
      serve(op % 2, op[2:0], 32'hFFFF_FFF0 + op, 32'd3 + op);
    end

    // Reset in EXEC drops the transaction
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'd0, 32'd2, 32'd3);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out", {busy, sels, bus.alu_operand_a, bus.rsp0_valid, bus.rsp1_valid},
        {1'b0, 5'd0, 32'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_norsp", {61'd0, bus.rsp0_valid, bus.rsp1_valid, busy}, 64'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'd2, 32'hF0F0, 32'hFF00);
    set_req(1, 1'b1, 3'd0, 32'd10, 32'd20);
    @(negedge clk);
    chk("midrst_tie", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd2);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    drain(0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'd0, '0, '0);
    drain(1);

    // Random traffic
    for (int i = 0; i < 12; i++) begin
      serve($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
